// File: rtl/xex_sched_pkg.sv
// Shared types for the XEX sector scheduler: engine mode codes, FSM states, block width.
package xex_sched_pkg;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_ENC  = 2'b10,
    MODE_DEC  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_FINISH
  } state_e;
endpackage

// File: rtl/xex_rr_arbiter.sv
// 2-way round-robin picker; the pointer moves to the non-owner whenever advance pulses.
module xex_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic [1:0] pick
);
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= 1'b0;
    else if (advance) ptr <= ~owner;
  end

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = 2'b00;
      pick[ptr] = 1'b1;
    end
  end
endmodule

// File: rtl/xex_sector_scheduler.sv
// Shares one XEX engine between two requesters a whole sector at a time.
// Optional watchdog abort is enabled with `define XEX_SCHED_WDOG_EN.
module xex_sector_scheduler
  import xex_sched_pkg::*;
#(
  parameter int BLOCKS_PER_SECTOR = 256,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [1:0][1:0]         req_mode,
  input  logic [1:0][BLOCK_W-1:0] req_sector,
  input  logic [1:0]              req_valid,
  input  logic [1:0][BLOCK_W-1:0] req_data,
  output logic [1:0]              req_ready,
  output logic [1:0]              gnt,
  output logic [1:0]              resp_valid,
  output logic [BLOCK_W-1:0]      resp_data,
  output logic [1:0]              done,
  output logic [1:0]              err,
  output logic                    eng_in_rdy,
  output logic [1:0]              eng_mode,
  output logic [BLOCK_W-1:0]      eng_sector,
  output logic [BLOCK_W-1:0]      eng_data_in,
  input  logic                    eng_busy,
  input  logic                    eng_out_rdy,
  input  logic [BLOCK_W-1:0]      eng_data_out
);
  localparam int CW = $clog2(BLOCKS_PER_SECTOR) + 1;
  localparam logic [CW-1:0] N = CW'(BLOCKS_PER_SECTOR);

  state_e              state, state_n;
  logic                own;
  mode_e               mode_r;
  logic [BLOCK_W-1:0]  sector_r;
  logic                err_flag;
  logic [CW-1:0]       iss_cnt, ret_cnt;
  logic [1:0]          pick;
  logic                pick_idx, bad_mode, busy_st, accept, resp, last_resp, timeout;

  xex_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(state == S_FINISH),
    .owner  (own),
    .pick   (pick)
  );

  assign pick_idx  = pick[1];
  assign bad_mode  = !req_mode[pick_idx][1];
  assign busy_st   = (state == S_STREAM) || (state == S_DRAIN);

  assign eng_in_rdy  = (state == S_STREAM) && req_valid[own] && (iss_cnt < N);
  assign eng_data_in = (state == S_STREAM) ? req_data[own] : '0;
  assign accept      = eng_in_rdy && !eng_busy;
  // Results arriving before the engine is streaming belong to nobody and are dropped.
  assign resp        = busy_st && eng_out_rdy;
  assign last_resp   = resp && (ret_cnt == N - 1'b1);

  assign req_ready  = accept ? (2'b01 << own) : 2'b00;
  assign resp_valid = resp   ? (2'b01 << own) : 2'b00;
  assign resp_data  = resp   ? eng_data_out   : '0;
  assign done       = (state == S_FINISH && !err_flag) ? gnt : 2'b00;
  assign err        = (state == S_FINISH &&  err_flag) ? gnt : 2'b00;
  assign eng_mode   = (state == S_LOAD || busy_st) ? mode_r : MODE_IDLE;
  assign eng_sector = sector_r;

`ifdef XEX_SCHED_WDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             wdog <= '0;
    else if (!busy_st || accept || resp) wdog <= '0;
    else                                 wdog <= wdog + 1'b1;
  end

  assign timeout = busy_st && !accept && !resp && (wdog == WW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (|req) state_n = bad_mode ? S_FINISH : S_LOAD;
      S_LOAD:   state_n = S_STREAM;
      S_STREAM,
      S_DRAIN: begin
        if (last_resp || timeout)                       state_n = S_FINISH;
        else if (state == S_STREAM && iss_cnt == N)     state_n = S_DRAIN;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      own      <= 1'b0;
      mode_r   <= MODE_IDLE;
      sector_r <= '0;
      err_flag <= 1'b0;
      iss_cnt  <= '0;
      ret_cnt  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (|req) begin
          gnt      <= pick;
          own      <= pick_idx;
          mode_r   <= mode_e'(req_mode[pick_idx]);
          sector_r <= req_sector[pick_idx];
          err_flag <= bad_mode;
        end
        S_LOAD: begin
          iss_cnt <= '0;
          ret_cnt <= '0;
        end
        S_STREAM,
        S_DRAIN: begin
          if (accept)  iss_cnt  <= iss_cnt + 1'b1;
          if (resp)    ret_cnt  <= ret_cnt + 1'b1;
          if (timeout) err_flag <= 1'b1;
        end
        S_FINISH: begin
          gnt      <= '0;
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
